// File: rtl/sram_port_ctrl_pkg.sv
// Shared definitions for the SRAM port controller and its response FIFO.
// The strobe-width formula lives here so the SRAM model and the controller
// derive byte-enable widths identically.
package sram_port_ctrl_pkg;

    // One strobe bit per started byte of data.
    function automatic int unsigned strb_width(input int unsigned dw);
        return (dw + 32'd7) / 32'd8;
    endfunction

    // FIFO operation in a given cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sram_port_ctrl_rsp_fifo.sv
// Read-response buffer: DEPTH x DW circular FIFO with a synchronous reset
// on the control state only. Storage is never reset; the head word is
// don't-care while the FIFO is empty.
module sram_rsp_fifo
    import sram_port_ctrl_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;
    fifo_op_e      op;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign op       = fifo_op_e'({do_push, do_pop});
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Data storage: written on push, intentionally left unreset.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            unique case (op)
                OP_PUSH: begin
                    wr_ptr <= ptr_inc(wr_ptr);
                    count  <= count + CW'(1);
                end
                OP_POP: begin
                    rd_ptr <= ptr_inc(rd_ptr);
                    count  <= count - CW'(1);
                end
                OP_BOTH: begin
                    wr_ptr <= ptr_inc(wr_ptr);
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                OP_IDLE: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Port controller for a two-port strobed SRAM with a registered 1-cycle read.
// Writes pass straight through; reads are credit-limited so every accepted
// request is guaranteed a slot in the response FIFO. A write and a read to
// the same address in the same cycle return write-first data, merged per
// byte one cycle later when the SRAM read data arrives.
module sram_port_ctrl
    import sram_port_ctrl_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 14,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned SW   = strb_width(DW)
) (
    input  logic          CLK,
    input  logic          RST,
    // write channel
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic [SW-1:0] w_strb,
    // read request channel
    input  logic          ar_valid,
    output logic          ar_ready,
    input  logic [AW-1:0] ar_addr,
    // read response channel
    output logic          r_valid,
    input  logic          r_ready,
    output logic [DW-1:0] r_data,
    // SRAM side
    output logic [DW-1:0] sram_data_w,
    output logic [AW-1:0] sram_addr_w,
    output logic [SW-1:0] sram_wstrb,
    output logic          sram_en_w,
    output logic [AW-1:0] sram_addr_r,
    output logic          sram_en_r,
    input  logic [DW-1:0] sram_data_r
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          w_hs;
    logic          ar_hs;
    logic          r_hs;
    logic [CW-1:0] cred;
    logic          rd_pend;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic [SW-1:0] hit_strb;
    logic [DW-1:0] merged;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;

    // Handshakes and SRAM-side pass-through.
    assign w_ready     = ~RST;
    assign w_hs        = w_valid & w_ready;
    assign sram_en_w   = w_hs;
    assign sram_addr_w = w_addr;
    assign sram_data_w = w_data;
    assign sram_wstrb  = w_strb;

    // ar_ready looks only at the current credit count, never at r_ready,
    // so there is no combinational path from the response side.
    assign ar_ready    = ~RST & (cred < CW'(DEPTH));
    assign ar_hs       = ar_valid & ar_ready;
    assign sram_en_r   = ar_hs;
    assign sram_addr_r = ar_addr;

    assign r_valid     = ~fifo_empty & ~RST;
    assign r_hs        = r_valid & r_ready;

    // Credits guarantee room; the full gate only protects against misuse.
    assign fifo_push   = rd_pend & ~fifo_full;

    // Credit counter, read-in-flight flag and same-address collision flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cred    <= '0;
            rd_pend <= 1'b0;
            hit     <= 1'b0;
        end else begin
            rd_pend <= ar_hs;
            hit     <= w_hs & ar_hs & (w_addr == ar_addr);
            case ({ar_hs, r_hs})
                2'b10:   cred <= cred + CW'(1);
                2'b01:   cred <= cred - CW'(1);
                default: cred <= cred;
            endcase
        end
    end

    // Write payload captured every cycle; only consumed when hit is set.
    always_ff @(posedge CLK) begin
        hit_data <= w_data;
        hit_strb <= w_strb;
    end

    // Byte-wise write-first merge over the SRAM read data (per bit so that
    // a partial final byte is handled too).
    always_comb begin
        merged = sram_data_r;
        for (int unsigned b = 0; b < DW; b++) begin
            if (hit && hit_strb[b / 8]) begin
                merged[b] = hit_data[b];
            end
        end
    end

    sram_rsp_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (fifo_push),
        .push_data (merged),
        .pop       (r_hs),
        .pop_data  (r_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Credits bound outstanding reads to DEPTH, so a landing read never
    // finds the FIFO full and the counter never exceeds DEPTH.
    a_cred_bound: assert property (@(posedge CLK) disable iff (RST)
        cred <= CW'(DEPTH));
    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(rd_pend && fifo_full));

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural two-port strobed SRAM
// (registered read, old data returned on same-cycle read/write).
module tb_sram_port_ctrl;
    import sram_port_ctrl_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 14;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned SW    = strb_width(DW);

    logic          CLK = 1'b0;
    logic          RST;
    logic          w_valid, w_ready;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;
    logic          ar_valid, ar_ready;
    logic [AW-1:0] ar_addr;
    logic          r_valid, r_ready;
    logic [DW-1:0] r_data;
    logic [DW-1:0] sram_data_w;
    logic [AW-1:0] sram_addr_w;
    logic [SW-1:0] sram_wstrb;
    logic          sram_en_w;
    logic [AW-1:0] sram_addr_r;
    logic          sram_en_r;
    logic [DW-1:0] sram_data_r;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 CLK = ~CLK;

    sram_port_ctrl #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .w_strb      (w_strb),
        .ar_valid    (ar_valid),
        .ar_ready    (ar_ready),
        .ar_addr     (ar_addr),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_data      (r_data),
        .sram_data_w (sram_data_w),
        .sram_addr_w (sram_addr_w),
        .sram_wstrb  (sram_wstrb),
        .sram_en_w   (sram_en_w),
        .sram_addr_r (sram_addr_r),
        .sram_en_r   (sram_en_r),
        .sram_data_r (sram_data_r)
    );

    // SRAM model: registered read, byte-strobed write, read sees old data.
    logic [DW-1:0] mem [0:(1 << AW) - 1];
    always @(posedge CLK) begin
        if (sram_en_r) sram_data_r <= mem[sram_addr_r];
        if (sram_en_w) begin
            for (int i = 0; i < int'(SW); i++) begin
                if (sram_wstrb[i]) mem[sram_addr_w][i*8 +: 8] <= sram_data_w[i*8 +: 8];
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Single write through the controller (w_ready is high out of reset).
    task automatic sram_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        w_valid = 1'b1; w_addr = a; w_data = d; w_strb = s;
        cyc();
        w_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; w_valid = 1'b1; ar_valid = 1'b1; r_ready = 1'b1;
        w_addr = '0; ar_addr = '0; w_data = '0; w_strb = '0;
        cyc(); cyc();
        #1;
        checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL reset_w_ready: got %b expected 0", w_ready); end
        checks++; if (ar_ready !== 1'b0) begin errors++; $display("FAIL reset_ar_ready: got %b expected 0", ar_ready); end
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid: got %b expected 0", r_valid); end
        checks++; if (sram_en_w !== 1'b0) begin errors++; $display("FAIL reset_sram_en_w: got %b expected 0", sram_en_w); end
        checks++; if (sram_en_r !== 1'b0) begin errors++; $display("FAIL reset_sram_en_r: got %b expected 0", sram_en_r); end
        RST = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        cyc();
        #1;
        checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL post_reset_w_ready: got %b expected 1", w_ready); end
        checks++; if (ar_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ar_ready: got %b expected 1", ar_ready); end
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL post_reset_r_valid: got %b expected 0", r_valid); end
        checks++; if (dut.cred !== 2'd0) begin errors++; $display("FAIL post_reset_cred: got %0d expected 0", dut.cred); end
        cyc();
    endtask

    task automatic test_passthrough();
        w_valid = 1'b1; w_addr = 14'h3ABC; w_data = 32'h1234_5678; w_strb = 4'b1010;
        #1;
        checks++; if (sram_en_w !== 1'b1) begin errors++; $display("FAIL pass_en_w: got %b expected 1", sram_en_w); end
        checks++; if (sram_addr_w !== 14'h3ABC) begin errors++; $display("FAIL pass_addr_w: got %h expected 3abc", sram_addr_w); end
        checks++; if (sram_data_w !== 32'h1234_5678) begin errors++; $display("FAIL pass_data_w: got %h expected 12345678", sram_data_w); end
        checks++; if (sram_wstrb !== 4'b1010) begin errors++; $display("FAIL pass_wstrb: got %b expected 1010", sram_wstrb); end
        cyc();
        w_valid = 1'b0;
        #1;
        checks++; if (sram_en_w !== 1'b0) begin errors++; $display("FAIL pass_en_w_idle: got %b expected 0", sram_en_w); end
        cyc();
    endtask

    task automatic test_single_read();
        sram_write(14'h0010, 32'hDEAD_BEEF, 4'hF);
        r_ready = 1'b1; ar_valid = 1'b1; ar_addr = 14'h0010;
        #1;
        checks++; if (sram_en_r !== 1'b1) begin errors++; $display("FAIL single_en_r: got %b expected 1", sram_en_r); end
        checks++; if (sram_addr_r !== 14'h0010) begin errors++; $display("FAIL single_addr_r: got %h expected 0010", sram_addr_r); end
        cyc();
        ar_valid = 1'b0;
        #1;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL single_r_valid_c1: got %b expected 0", r_valid); end
        cyc();
        #1;
        checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL single_r_valid_c2: got %b expected 1", r_valid); end
        checks++; if (r_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_r_data: got %h expected deadbeef", r_data); end
        cyc();
        #1;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL single_r_valid_c3: got %b expected 0", r_valid); end
        checks++; if (dut.cred !== 2'd0) begin errors++; $display("FAIL single_cred: got %0d expected 0", dut.cred); end
        cyc();
    endtask

    task automatic test_collision();
        sram_write(14'h0020, 32'h1122_3344, 4'hF);
        r_ready = 1'b1;
        w_valid = 1'b1; w_addr = 14'h0020; w_data = 32'hAABB_CCDD; w_strb = 4'b0101;
        ar_valid = 1'b1; ar_addr = 14'h0020;
        #1;
        checks++; if ({sram_en_w, sram_en_r} !== 2'b11) begin errors++; $display("FAIL coll_both_en: got %b expected 11", {sram_en_w, sram_en_r}); end
        cyc();
        w_valid = 1'b0; ar_valid = 1'b0;
        cyc();
        #1;
        checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL coll_r_valid: got %b expected 1", r_valid); end
        checks++; if (r_data !== 32'h11BB_33DD) begin errors++; $display("FAIL coll_r_data: got %h expected 11bb33dd", r_data); end
        cyc();
        ar_valid = 1'b1; ar_addr = 14'h0020;
        cyc();
        ar_valid = 1'b0;
        cyc();
        #1;
        checks++; if (r_data !== 32'h11BB_33DD || r_valid !== 1'b1) begin errors++; $display("FAIL coll_reread: got %b/%h expected 1/11bb33dd", r_valid, r_data); end
        cyc();
    endtask

    task automatic test_backpressure();
        int unsigned hs;
        logic        took;
        sram_write(14'h0040, 32'hA0A0_0001, 4'hF);
        sram_write(14'h0041, 32'hA0A0_0002, 4'hF);
        sram_write(14'h0042, 32'hA0A0_0003, 4'hF);
        hs = 0;
        r_ready = 1'b0; ar_valid = 1'b1; ar_addr = 14'h0040;
        for (int i = 0; i < 6; i++) begin
            #1;
            took = ar_ready;
            if (took) hs++;
            cyc();
            if (took) ar_addr = ar_addr + 14'd1;
        end
        ar_valid = 1'b0;
        #1;
        checks++; if (hs !== 2) begin errors++; $display("FAIL bp_handshakes: got %0d expected 2", hs); end
        checks++; if (ar_ready !== 1'b0) begin errors++; $display("FAIL bp_ar_ready_stalled: got %b expected 0", ar_ready); end
        checks++; if (r_valid !== 1'b1 || r_data !== 32'hA0A0_0001) begin errors++; $display("FAIL bp_held_head: got %b/%h expected 1/a0a00001", r_valid, r_data); end
        r_ready = 1'b1;
        cyc();
        #1;
        checks++; if (r_valid !== 1'b1 || r_data !== 32'hA0A0_0002) begin errors++; $display("FAIL bp_second: got %b/%h expected 1/a0a00002", r_valid, r_data); end
        checks++; if (ar_ready !== 1'b1) begin errors++; $display("FAIL bp_ar_ready_freed: got %b expected 1", ar_ready); end
        cyc();
        #1;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", r_valid); end
        checks++; if (dut.cred !== 2'd0) begin errors++; $display("FAIL bp_cred: got %0d expected 0", dut.cred); end
        cyc();
    endtask

    task automatic test_streaming();
        int unsigned nreq, nrsp, first;
        for (int i = 0; i < 16; i++) sram_write(14'(i), 32'hC0DE_0000 + 32'(i), 4'hF);
        nreq = 0; nrsp = 0; first = 999;
        r_ready = 1'b1;
        for (int c = 0; c < 80 && nrsp < 16; c++) begin
            ar_valid = (nreq < 16);
            ar_addr  = 14'(nreq);
            #1;
            if (r_valid) begin
                if (nrsp == 0) first = c;
                checks++;
                if (r_data !== 32'hC0DE_0000 + 32'(nrsp)) begin
                    errors++; $display("FAIL stream_data_%0d: got %h expected %h", nrsp, r_data, 32'hC0DE_0000 + 32'(nrsp));
                end
                nrsp++;
            end
            if (ar_valid && ar_ready) nreq++;
            cyc();
        end
        ar_valid = 1'b0;
        checks++; if (nrsp !== 16) begin errors++; $display("FAIL stream_count: got %0d expected 16 (cycle budget)", nrsp); end
        checks++; if (first !== 2) begin errors++; $display("FAIL stream_first_cycle: got %0d expected 2", first); end
        #1;
        checks++; if (dut.cred !== 2'd0) begin errors++; $display("FAIL stream_cred: got %0d expected 0", dut.cred); end
        cyc();
    endtask

    task automatic test_write_after_read();
        sram_write(14'h0030, 32'h0000_0000, 4'hF);
        r_ready = 1'b1; ar_valid = 1'b1; ar_addr = 14'h0030;
        cyc();
        ar_valid = 1'b0;
        w_valid = 1'b1; w_addr = 14'h0030; w_data = 32'hFFFF_FFFF; w_strb = 4'hF;
        cyc();
        w_valid = 1'b0;
        #1;
        checks++; if (r_valid !== 1'b1 || r_data !== 32'h0000_0000) begin errors++; $display("FAIL war_old_data: got %b/%h expected 1/00000000", r_valid, r_data); end
        cyc();
        ar_valid = 1'b1;
        cyc();
        ar_valid = 1'b0;
        cyc();
        #1;
        checks++; if (r_valid !== 1'b1 || r_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL war_new_data: got %b/%h expected 1/ffffffff", r_valid, r_data); end
        cyc();
    endtask

    task automatic test_reset_mid();
        int unsigned seen;
        sram_write(14'h0050, 32'h5555_AAAA, 4'hF);
        r_ready = 1'b1; ar_valid = 1'b1; ar_addr = 14'h0050;
        #1;
        checks++; if (ar_ready !== 1'b1) begin errors++; $display("FAIL rstmid_accept: got %b expected 1", ar_ready); end
        cyc();
        ar_valid = 1'b0; RST = 1'b1;
        #1;
        checks++; if (r_valid !== 1'b0 || ar_ready !== 1'b0) begin errors++; $display("FAIL rstmid_during: got r_valid=%b ar_ready=%b expected 0/0", r_valid, ar_ready); end
        cyc();
        RST = 1'b0;
        #1;
        checks++; if (ar_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ar_ready: got %b expected 1", ar_ready); end
        checks++; if (dut.cred !== 2'd0) begin errors++; $display("FAIL rstmid_cred: got %0d expected 0", dut.cred); end
        seen = (r_valid === 1'b1) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            if (r_valid !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_response: got %0d valid cycles expected 0", seen); end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; w_valid = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
        w_addr = '0; w_data = '0; w_strb = '0; ar_addr = '0;
        test_reset();
        test_passthrough();
        test_single_read();
        test_collision();
        test_backpressure();
        test_streaming();
        test_write_after_read();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
